// File: rtl/adder_pkg.sv
// Shared constants and helpers for the sliced pipelined adder.
package adder_pkg;

   localparam int unsigned DEFAULT_WIDTH  = 4;
   localparam int unsigned DEFAULT_STAGES = 2;

   // Width of a counter that must represent 0..stages inclusive.
   function automatic int unsigned clog2_occ(input int unsigned stages);
      return (stages < 1) ? 1 : $clog2(stages + 1);
   endfunction

endpackage

// File: rtl/add_slice_stage.sv
// One pipeline slice: adds slice IDX of the carried operands plus the incoming
// carry, and holds the result with a valid bit under local advance control.
module add_slice_stage
   import adder_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH,
   parameter int unsigned SW    = DEFAULT_WIDTH / DEFAULT_STAGES,
   parameter int unsigned IDX   = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             up_valid_i,
   input  logic [WIDTH-1:0] up_a_i,
   input  logic [WIDTH-1:0] up_b_i,
   input  logic [WIDTH-1:0] up_part_i,
   input  logic             up_carry_i,
   input  logic             dn_ready_i,
   output logic             ready_o,
   output logic             valid_o,
   output logic [WIDTH-1:0] a_o,
   output logic [WIDTH-1:0] b_o,
   output logic [WIDTH-1:0] part_o,
   output logic             carry_o
);

   logic             valid_q;
   logic [WIDTH-1:0] a_q, b_q, part_q, part_d;
   logic             carry_q;
   logic [SW:0]      slice_sum;

   // Bubble-collapsing: an empty stage always loads, a full one only when drained.
   assign ready_o = !valid_q || dn_ready_i;

   always_comb begin
      slice_sum = {1'b0, up_a_i[IDX*SW +: SW]} + {1'b0, up_b_i[IDX*SW +: SW]}
                + {{SW{1'b0}}, up_carry_i};
      part_d = up_part_i;
      part_d[IDX*SW +: SW] = slice_sum[SW-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         part_q  <= '0;
         carry_q <= 1'b0;
      end else if (ready_o) begin
         valid_q <= up_valid_i;
         if (up_valid_i) begin
            a_q     <= up_a_i;
            b_q     <= up_b_i;
            part_q  <= part_d;
            carry_q <= slice_sum[SW];
         end
      end
   end

   assign valid_o = valid_q;
   assign a_o     = a_q;
   assign b_o     = b_q;
   assign part_o  = part_q;
   assign carry_o = carry_q;

endmodule

// File: rtl/pipelined_slice_adder.sv
// WIDTH-bit adder with carry-in, carry chain split over STAGES registered
// slices, valid/ready on both sides and a registered occupancy count.
module pipelined_slice_adder
   import adder_pkg::*;
#(
   parameter int unsigned WIDTH  = DEFAULT_WIDTH,
   parameter int unsigned STAGES = DEFAULT_STAGES
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [WIDTH-1:0]                a,
   input  logic [WIDTH-1:0]                b,
   input  logic                            cin,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [WIDTH:0]                  sum,
   output logic [clog2_occ(STAGES)-1:0]    occupancy
);

   localparam int unsigned SW = WIDTH / STAGES;
   localparam int unsigned OW = clog2_occ(STAGES);

   if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
      $error("pipelined_slice_adder: WIDTH must be a multiple of STAGES and STAGES >= 1");
   end

   // Element k is the input of stage k; element STAGES is the final stage output.
   logic [STAGES:0]  vld, carry, rdy;
   logic [WIDTH-1:0] part [STAGES+1];
   logic [WIDTH-1:0] op_a [STAGES];
   logic [WIDTH-1:0] op_b [STAGES];

   assign vld[0]      = in_valid;
   assign carry[0]    = cin;
   assign part[0]     = '0;
   assign op_a[0]     = a;
   assign op_b[0]     = b;
   assign rdy[STAGES] = out_ready;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [WIDTH-1:0] pass_a, pass_b;

      add_slice_stage #(
         .WIDTH (WIDTH),
         .SW    (SW),
         .IDX   (k)
      ) u_stage (
         .clk        (clk),
         .rst_n      (rst_n),
         .up_valid_i (vld[k]),
         .up_a_i     (op_a[k]),
         .up_b_i     (op_b[k]),
         .up_part_i  (part[k]),
         .up_carry_i (carry[k]),
         .dn_ready_i (rdy[k+1]),
         .ready_o    (rdy[k]),
         .valid_o    (vld[k+1]),
         .a_o        (pass_a),
         .b_o        (pass_b),
         .part_o     (part[k+1]),
         .carry_o    (carry[k+1])
      );

      if (k < STAGES - 1) begin : g_fwd
         assign op_a[k+1] = pass_a;
         assign op_b[k+1] = pass_b;
      end else begin : g_tail
         logic unused_ops;
         assign unused_ops = ^{pass_a, pass_b};
      end
   end

   assign in_ready  = rdy[0];
   assign out_valid = vld[STAGES];
   assign sum       = out_valid ? {carry[STAGES], part[STAGES]} : '0;

   logic          in_fire, out_fire;
   logic [OW-1:0] occ_q, occ_d;

   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;

   always_comb begin
      occ_d = occ_q;
      if (in_fire && !out_fire)
         occ_d = occ_q + OW'(1);
      else if (!in_fire && out_fire)
         occ_d = occ_q - OW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         occ_q <= '0;
      else
         occ_q <= occ_d;
   end

   assign occupancy = occ_q;

endmodule
